rom_fetch_unit: RTL and testbench

- Read-side initiator for the instruction ROM: generates sequential fetch addresses, issues ROM reads, and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents buffered words to the decode stage over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.
- Sits between the ROM and the decode stage of the RISC-V core.

---
 rtl/rom_fetch_unit_pkg.sv | 15 +
 rtl/rom_fetch_unit_fifo.sv | 54 +++++
 rtl/rom_fetch_unit.sv | 90 +++++++++
 tb/tb_rom_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_unit_pkg.sv
// Shared constants and entry type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned INSTR_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PC_INC      = INSTR_BYTES;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// Synchronous show-ahead FIFO holding fetched {pc, instr} pairs.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned depth = FIFO_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned ptr_w = $clog2(depth),
  localparam int unsigned cnt_w = ptr_w + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [cnt_w-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  entry_t             mem [depth];
  logic [ptr_w-1:0]   wr_ptr, rd_ptr;
  logic [cnt_w-1:0]   count;
  logic               do_push, do_pop;

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Depth is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == cnt_w'(depth));

endmodule

// File: rtl/rom_fetch_unit.sv
// Sequential ROM fetch with a prefetch FIFO, redirect flush and valid/ready output.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned addr_width = ADDR_WIDTH,
  parameter int unsigned fifo_depth = FIFO_DEPTH,
  parameter logic [addr_width-1:0] reset_pc = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  rom_en_o,
  output logic [addr_width-1:0] rom_addr_o,
  input  logic [data_width-1:0] rom_data_i,
  input  logic                  redirect_i,
  input  logic [addr_width-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [data_width-1:0] instr_o,
  output logic [addr_width-1:0] instr_pc_o
);

  localparam int unsigned cnt_w  = $clog2(fifo_depth) + 1;
  localparam int unsigned pc_inc = data_width / 8;

  typedef struct packed {
    logic [addr_width-1:0] pc;
    logic [data_width-1:0] instr;
  } entry_t;

  logic [addr_width-1:0] pc_q, req_pc_q;
  logic                  inflight_q;
  logic [cnt_w-1:0]      count;
  logic                  empty, full;
  logic                  issue, push, pop;
  entry_t                head, push_entry;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Slot reservation counts the in-flight request; same-cycle pops are not credited.
  always_comb begin
    issue = rst_ni && !redirect_i && !full &&
            ((int'(count) + int'(inflight_q)) < int'(fifo_depth));
    push  = inflight_q && !redirect_i;
    pop   = !empty && instr_ready_i;
    push_entry.pc    = req_pc_q;
    push_entry.instr = rom_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q       <= reset_pc;
      req_pc_q   <= reset_pc;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[addr_width-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + addr_width'(pc_inc);
      end
    end
  end

  fetch_fifo #(
    .depth   (fifo_depth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign rom_en_o      = issue;
  assign rom_addr_o    = pc_q;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head.instr;
  assign instr_pc_o    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed and randomized checks of rom_fetch_unit against a queue-based model.
module tb_rom_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  rom_fetch_unit #(
    .data_width (32),
    .addr_width (32),
    .fifo_depth (4),
    .reset_pc   (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .rom_en_o      (rom_en),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  // ROM contents: word i holds 0x1000_0000 + i; synchronous one-cycle read.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: every request issued since the last flush that decode has not yet taken.
  int          q_cyc[$];
  logic [31:0] q_pc[$];
  logic [31:0] mpc = 32'h0;
  int          cyc = 0;
  bit          armed = 0;
  logic        prev_rst = 1'b1;
  bit          stall_prev = 0;
  logic [31:0] prev_instr, prev_pc;
  int          issues = 0;

  task automatic step();
    bit ev, en;
    @(negedge clk);
    ev = (q_cyc.size() > 0) && (q_cyc[0] <= cyc - 2);
    en = rst_ni && !redirect && (q_cyc.size() < 4);
    if (armed) begin
      chk("rom_en", 64'(rom_en), 64'(en));
      chk("rom_addr", 64'(rom_addr), 64'(mpc));
      chk("instr_valid", 64'(instr_valid), 64'(ev));
      if (ev) begin
        chk("instr", 64'(instr), 64'(rom_word(q_pc[0])));
        chk("instr_pc", 64'(instr_pc), 64'(q_pc[0]));
      end
      if (!prev_rst) begin
        chk("reset_instr", 64'(instr), 64'h0);
        chk("reset_instr_pc", 64'(instr_pc), 64'h0);
      end
      if (stall_prev && ev) begin
        chk("stable_instr", 64'(instr), 64'(prev_instr));
        chk("stable_pc", 64'(instr_pc), 64'(prev_pc));
      end
    end
    stall_prev = ev && !instr_ready && rst_ni && !redirect;
    prev_instr = instr;
    prev_pc    = instr_pc;
    @(posedge clk);
    if (!rst_ni) begin
      q_cyc.delete(); q_pc.delete(); mpc = 32'h0;
    end else if (redirect) begin
      q_cyc.delete(); q_pc.delete(); mpc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (ev && instr_ready) begin
        void'(q_cyc.pop_front()); void'(q_pc.pop_front());
      end
      if (en) begin
        q_cyc.push_back(cyc); q_pc.push_back(mpc);
        mpc = mpc + 32'd4;
        issues++;
      end
    end
    prev_rst = rst_ni;
    cyc++;
    armed = 1;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_ni = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    steps(3);

    // Streaming with ready held high: one word per cycle after two-cycle latency.
    rst_ni = 1'b1;
    steps(12);

    // Decode stalled from reset: exactly four issues, then resume at 16.
    rst_ni = 1'b0; step();
    rst_ni = 1'b1; instr_ready = 1'b0;
    issues = 0;
    steps(7);
    chk("stall_issue_count", 64'(issues), 64'd4);
    instr_ready = 1'b1;
    steps(8);

    // Redirect with three buffered entries and one request in flight.
    rst_ni = 1'b0; step();
    rst_ni = 1'b1; instr_ready = 1'b0;
    steps(4);
    redirect = 1'b1; redirect_pc = 32'h40; step();
    redirect = 1'b0; instr_ready = 1'b1;
    steps(6);

    // Address wrap and unaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
    redirect = 1'b0; steps(5);
    redirect = 1'b1; redirect_pc = 32'h43; step();
    redirect = 1'b0; steps(5);

    // Reset mid-stream with a full FIFO.
    instr_ready = 1'b0; steps(6);
    rst_ni = 1'b0; step();
    rst_ni = 1'b1; instr_ready = 1'b1; steps(6);

    // Random ready with occasional redirects.
    for (int i = 0; i < 200; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = $urandom();
      step();
    end
    redirect = 1'b0; instr_ready = 1'b1;
    steps(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
